// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: op encoding and the
// width-independent part of a pipeline stage record.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROL = 2'd3
    } shift_op_e;

    // Control half of a stage record; data and amount widths depend on WIDTH
    // and are added by the top level.
    typedef struct packed {
        logic      valid;
        shift_op_e op;
    } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One step of the barrel shifter: conditionally shifts by STEP in the selected
// mode. Purely combinational.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic             sel,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] rol;

    always_comb begin
        shl = data << STEP;
        shr = data >> STEP;
        // The MSB is still the original sign bit after earlier SRA steps,
        // so sign-filling from the current word is exact.
        sra = $signed(data) >>> STEP;
        rol = (data << STEP) | (data >> (WIDTH - STEP));
        result = data;
        if (sel) begin
            case (shift_op_e'(op))
                OP_SLL:  result = shl;
                OP_SRL:  result = shr;
                OP_SRA:  result = sra;
                OP_ROL:  result = rol;
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with a
// single global advance enable driven by downstream backpressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    amt;
    } stage_t;

    stage_t [AW-1:0]           stg_q;
    stage_t [AW-1:0]           src;
    stage_t [AW-1:0]           nxt;
    logic   [AW-1:0][WIDTH-1:0] shifted;
    logic                       zero_q;
    logic                       en;

    // Stage k consumes the previous stage register (or the input port for k=0).
    always_comb begin
        src[0].ctrl.valid = in_valid;
        src[0].ctrl.op    = shift_op_e'(in_op);
        src[0].data       = in_data;
        src[0].amt        = in_amt;
        for (int k = 1; k < AW; k++) begin
            src[k] = stg_q[k-1];
        end
        for (int k = 0; k < AW; k++) begin
            nxt[k]      = src[k];
            nxt[k].data = shifted[k];
        end
    end

    for (genvar k = 0; k < AW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << k)
        ) u_stage (
            .data   (src[k].data),
            .op     (src[k].ctrl.op),
            .sel    (src[k].amt[k]),
            .result (shifted[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q  <= '0;
            zero_q <= 1'b0;
        end else if (en) begin
            stg_q  <= nxt;
            zero_q <= nxt[AW-1].ctrl.valid && (nxt[AW-1].data == '0);
        end
    end

    assign out_valid = stg_q[AW-1].ctrl.valid;
    assign out_data  = stg_q[AW-1].data;
    assign out_zero  = zero_q;
    // Whole pipeline advances together; bubbles are not squeezed out.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

endmodule
